prbs_lfsr: RTL

PRBS_LFSR -- requirements
Module: prbs_lfsr

---
 rtl/prbs_if.sv | 26 ++
 rtl/prbs_lfsr.sv | 134 +++++++++++++
 2 files changed

// File: rtl/prbs_if.sv
// Command and status bundle for the PRBS LFSR: a master drives the commands,
// and the LFSR (slave) returns its register contents and status flags.
interface prbs_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             run;
  logic             shift;
  logic             serial_in;
  logic [WIDTH-1:0] state;
  logic             serial_out;
  logic             wrap;
  logic             lockup;
  logic [WIDTH-1:0] step_cnt;

  modport master (
    output load, seed_in, run, shift, serial_in,
    input  state, serial_out, wrap, lockup, step_cnt
  );

  modport slave (
    input  load, seed_in, run, shift, serial_in,
    output state, serial_out, wrap, lockup, step_cnt
  );
endinterface

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR with seed load, serial shift-in, wrap detection against the
// last seed, and one-cycle recovery from the all-zero lockup state.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no run last cycle; load/shift/hold as commanded
// S_RUN     | stepping the LFSR on every cycle that run stays high
// S_RECOVER | all-zero state seen under run; reseed from SEED_DEF, flag it
module prbs_lfsr #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED_DEF = WIDTH'(1)
) (
  input  logic   clk,
  input  logic   rst,
  prbs_if.slave  bus
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("prbs_lfsr: WIDTH must be in 3..32");
  end
  if (SEED_DEF == '0) begin : g_bad_seed
    $error("prbs_lfsr: SEED_DEF must be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RECOVER = 2'd2
  } fsm_e;

  fsm_e fsm_q, fsm_d;

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] ref_q,  ref_d;
  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic             wrap_q, wrap_d;
  logic             lock_q, lock_d;

  logic             fb;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] shift_val;
  logic             at_zero;
  logic             hit_ref;

  assign fb        = ^(lfsr_q & TAPS);
  assign step_val  = {lfsr_q[WIDTH-2:0], fb};
  assign shift_val = {lfsr_q[WIDTH-2:0], bus.serial_in};
  assign at_zero   = (lfsr_q == '0);
  assign hit_ref   = (step_val == ref_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= S_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE: begin
        if (bus.run && !bus.load) begin
          fsm_d = at_zero ? S_RECOVER : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.load || !bus.run) begin
          fsm_d = S_IDLE;
        end else if (at_zero) begin
          fsm_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        fsm_d = bus.run ? S_RUN : S_IDLE;
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // RECOVER overrides every command, including load, for its single cycle.
  always_comb begin
    lfsr_d = lfsr_q;
    ref_d  = ref_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    lock_d = lock_q;
    if (fsm_q == S_RECOVER) begin
      lfsr_d = SEED_DEF;
      ref_d  = SEED_DEF;
      cnt_d  = '0;
      lock_d = 1'b1;
    end else if (bus.load) begin
      lfsr_d = bus.seed_in;
      ref_d  = bus.seed_in;
      cnt_d  = '0;
      lock_d = 1'b0;
    end else if (bus.run) begin
      if (!at_zero) begin
        lfsr_d = step_val;
        wrap_d = hit_ref;
        cnt_d  = hit_ref ? '0 : cnt_q + WIDTH'(1);
      end
    end else if (bus.shift) begin
      lfsr_d = shift_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED_DEF;
      ref_q  <= SEED_DEF;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      ref_q  <= ref_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      lock_q <= lock_d;
    end
  end

  assign bus.state      = lfsr_q;
  assign bus.serial_out = lfsr_q[WIDTH-1];
  assign bus.wrap       = wrap_q;
  assign bus.lockup     = lock_q;
  assign bus.step_cnt   = cnt_q;

endmodule
